// File: rtl/countdown_timer.sv
// Down-counting seconds timer for the game time limit, with a 4-digit
// multiplexed 7-segment scan (ones, tens, hundreds, blank) matching the session timer.
module countdown_timer #(
  parameter int TICK_DIV = 100000000,
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [9:0] init_sec,
  input  logic       start,
  input  logic       endn,
  output logic [9:0] sec,
  output logic [3:0] bcd,
  output logic [1:0] digit,
  output logic       a0,
  output logic       a1,
  output logic       a2,
  output logic       a3,
  output logic       busy,
  output logic       done,
  output logic       expired,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic [SW-1:0] scan;
  logic [9:0]    load_val;

  assign load_val = (init_sec > 10'd999) ? 10'd999 : init_sec;

  // Control handshake: load is a one-edge strobe that wins over everything;
  // start/endn are levels, run requires start=1 and endn=0 on every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sec     <= 10'd0;
      presc   <= '0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (load) begin
        sec   <= load_val;
        presc <= '0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && !endn) begin
              presc <= '0;
              if (sec != 10'd0) begin
                state <= RUN;
              end else begin
                state   <= DONE;
                expired <= 1'b1;
              end
            end
          end
          RUN: begin
            // Stopping discards the partial second, so a resume waits a full period.
            if (endn || !start) begin
              state <= IDLE;
              presc <= '0;
            end else if (presc == TICK_LAST) begin
              presc <= '0;
              if (sec != 10'd0) begin
                sec <= sec - 10'd1;
                if (sec == 10'd1) begin
                  state   <= DONE;
                  expired <= 1'b1;
                end
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          DONE: begin
            presc <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan  <= '0;
      digit <= 2'd0;
    end else if (scan == SCAN_LAST) begin
      scan  <= '0;
      digit <= digit + 2'd1;
    end else begin
      scan <= scan + SW'(1);
    end
  end

  always_comb begin
    bcd = 4'hF;
    case (digit)
      2'd0:    bcd = 4'(sec % 10'd10);
      2'd1:    bcd = 4'((sec / 10'd10) % 10'd10);
      2'd2:    bcd = 4'(sec / 10'd100);
      default: bcd = 4'hF;
    endcase
  end

  assign a0        = (digit != 2'd0);
  assign a1        = (digit != 2'd1);
  assign a2        = (digit != 2'd2);
  assign a3        = (digit != 2'd3);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4, SCAN_DIV=2; inputs change
// and outputs are sampled on the falling edge.
module tb_countdown_timer;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic       clk;
  logic       rst;
  logic       load;
  logic [9:0] init_sec;
  logic       start;
  logic       endn;
  logic [9:0] sec;
  logic [3:0] bcd;
  logic [1:0] digit;
  logic       a0, a1, a2, a3;
  logic       busy;
  logic       done;
  logic       expired;
  logic [1:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;

  countdown_timer #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
    .clk(clk), .rst(rst), .load(load), .init_sec(init_sec),
    .start(start), .endn(endn), .sec(sec), .bcd(bcd), .digit(digit),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .busy(busy), .done(done),
    .expired(expired), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Async reset, released on a falling edge so the scan phase is known afterwards.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; init_sec = 10'd0; start = 1'b0; endn = 1'b0;
    #3;
    check("rst_sec",     16'(sec), 16'd0);
    check("rst_anodes",  16'({a3, a2, a1, a0}), 16'b1110);
    check("rst_bcd",     16'(bcd), 16'd0);
    check("rst_flags",   16'({busy, done, expired}), 16'b000);
    check("rst_state",   16'(state_dbg), 16'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;

    // Basic countdown from 3
    load = 1'b1; init_sec = 10'd3; step(1);
    load = 1'b0;
    check("load3_sec", 16'(sec), 16'd3);
    check("load3_idle", 16'(state_dbg), 16'(S_IDLE));
    start = 1'b1; step(1);
    check("run_busy", 16'({busy, done}), 16'b10);
    step(3);
    check("run_hold3", 16'(sec), 16'd3);
    step(1);
    check("run_sec2", 16'(sec), 16'd2);
    step(4);
    check("run_sec1", 16'(sec), 16'd1);
    step(3);
    check("run_pre0", 16'({sec, expired}), {5'd0, 10'd1, 1'b0});
    step(1);
    check("exp_sec0", 16'(sec), 16'd0);
    check("exp_pulse", 16'({busy, done, expired}), 16'b011);
    step(1);
    check("exp_low", 16'({busy, done, expired}), 16'b010);
    endn = 1'b1; start = 1'b0; step(2);
    check("done_ignores", 16'({sec, done}), {5'd0, 10'd0, 1'b1});
    endn = 1'b0;

    // Clamp and display scan
    do_reset();
    load = 1'b1; init_sec = 10'd1023; step(1);
    load = 1'b0;
    check("clamp_999", 16'(sec), 16'd999);
    check("scan_d0", 16'({digit, bcd, a3, a2, a1, a0}), {6'd0, 2'd0, 4'd9, 4'b1110});
    step(1);
    check("scan_d1", 16'({digit, bcd, a3, a2, a1, a0}), {6'd0, 2'd1, 4'd9, 4'b1101});
    step(1);
    check("scan_d1_hold", 16'(digit), 16'd1);
    step(1);
    check("scan_d2", 16'({digit, bcd, a3, a2, a1, a0}), {6'd0, 2'd2, 4'd9, 4'b1011});
    step(2);
    check("scan_d3", 16'({digit, bcd, a3, a2, a1, a0}), {6'd0, 2'd3, 4'hF, 4'b0111});
    step(2);
    check("scan_wrap", 16'({digit, a3, a2, a1, a0}), {10'd0, 2'd0, 4'b1110});

    // Distinct digits to catch digit/weight swaps
    do_reset();
    load = 1'b1; init_sec = 10'd123; step(1);
    load = 1'b0;
    check("bcd_ones", 16'(bcd), 16'd3);
    step(1);
    check("bcd_tens", 16'(bcd), 16'd2);
    step(2);
    check("bcd_hund", 16'(bcd), 16'd1);
    step(2);
    check("bcd_blank", 16'(bcd), 16'hF);
    load = 1'b1; init_sec = 10'd1000; step(1);
    check("clamp_1000", 16'(sec), 16'd999);
    init_sec = 10'd999; step(1);
    check("load_999", 16'(sec), 16'd999);
    load = 1'b0;

    // Freeze and resume
    load = 1'b1; init_sec = 10'd8; step(1);
    load = 1'b0; start = 1'b1; step(1);
    check("frz_run", 16'(busy), 16'd1);
    step(12);
    check("frz_sec5", 16'(sec), 16'd5);
    endn = 1'b1; step(1);
    check("frz_idle", 16'({sec, busy}), {5'd0, 10'd5, 1'b0});
    step(6);
    check("frz_hold", 16'({sec, state_dbg}), {4'd0, 10'd5, S_IDLE});
    endn = 1'b0; step(1);
    check("res_busy", 16'(busy), 16'd1);
    step(3);
    check("res_hold5", 16'(sec), 16'd5);
    step(1);
    check("res_sec4", 16'(sec), 16'd4);

    // Stop coincident with tick: no decrement
    step(3);
    endn = 1'b1; step(1);
    check("stop_prio", 16'({sec, busy}), {5'd0, 10'd4, 1'b0});
    endn = 1'b0; start = 1'b0;

    // Start from zero goes straight to DONE
    load = 1'b1; init_sec = 10'd0; step(1);
    load = 1'b0;
    check("zero_idle", 16'({sec, done}), 16'd0);
    start = 1'b1; step(1);
    check("zero_done", 16'({busy, done, expired}), 16'b011);
    step(1);
    check("zero_once", 16'({sec, done, expired}), {5'd0, 10'd0, 1'b1, 1'b0});

    // Async reset mid-RUN
    load = 1'b1; init_sec = 10'd9; step(1);
    load = 1'b0; step(3);
    check("pre_rst_busy", 16'(busy), 16'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_sec", 16'(sec), 16'd0);
    check("arst_out", 16'({busy, a3, a2, a1, a0}), 16'b01110);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    // Reload from DONE
    load = 1'b1; init_sec = 10'd1; step(1);
    load = 1'b0; start = 1'b1; step(5);
    check("reach_done", 16'({sec, done}), {5'd0, 10'd0, 1'b1});
    load = 1'b1; init_sec = 10'd7; step(1);
    load = 1'b0; start = 1'b0;
    check("reload_7", 16'({sec, done, busy}), {4'd0, 10'd7, 2'b00});
    check("reload_idle", 16'(state_dbg), 16'(S_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
